// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants, colour palette and screen edges
// used by the timing generator and the game renderer.
package vga_pkg;

   localparam int unsigned VGA_CLK_DIV      = 4;
   localparam int unsigned VGA_H_TOTAL      = 800;
   localparam int unsigned VGA_H_SYNC       = 96;
   localparam int unsigned VGA_H_DISP_START = 144;
   localparam int unsigned VGA_H_DISP_END   = 784;
   localparam int unsigned VGA_V_TOTAL      = 525;
   localparam int unsigned VGA_V_SYNC       = 2;
   localparam int unsigned VGA_V_DISP_START = 35;
   localparam int unsigned VGA_V_DISP_END   = 515;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam logic [11:0] RED          = 12'hF00;
   localparam logic [11:0] WHITE        = 12'hFFF;
   localparam logic [11:0] PINK         = 12'hF6B;
   localparam logic [11:0] BLUE         = 12'h00F;
   localparam logic [11:0] BRIGHT_GREEN = 12'h0F0;
   localparam logic [11:0] BLACK        = 12'h000;
   localparam logic [11:0] PURPLE       = 12'h80F;

   // Inclusive edges of the visible area in counter coordinates.
   localparam int unsigned SCREEN_LEFT   = VGA_H_DISP_START;
   localparam int unsigned SCREEN_RIGHT  = VGA_H_DISP_END - 1;
   localparam int unsigned SCREEN_TOP    = VGA_V_DISP_START;
   localparam int unsigned SCREEN_BOTTOM = VGA_V_DISP_END - 1;

   // 11-bit operands so an end bound of 1024 still compares correctly.
   function automatic logic in_window(input logic [10:0] pos,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/clk_en_div.sv
// Free-running divider producing a one-clk enable every DIV clocks;
// with DIV=1 the enable is constantly high.
module clk_en_div #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic en
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] div_q;
   logic [W-1:0] div_d;

   // Next divider value and the strobe on the last count.
   always_comb begin
      en = (div_q == LAST);
      if (en) begin
         div_d = '0;
      end else begin
         div_d = div_q + W'(1);
      end
   end

   // Divider register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing master: pixel enable, h/v counters, bright decode,
// registered sync/colour pins and line/vblank/frame strobes.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV      = VGA_CLK_DIV,
   parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
   parameter int unsigned H_SYNC       = VGA_H_SYNC,
   parameter int unsigned H_DISP_START = VGA_H_DISP_START,
   parameter int unsigned H_DISP_END   = VGA_H_DISP_END,
   parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
   parameter int unsigned V_SYNC       = VGA_V_SYNC,
   parameter int unsigned V_DISP_START = VGA_V_DISP_START,
   parameter int unsigned V_DISP_END   = VGA_V_DISP_END
) (
   input  logic        clk,
   input  logic        rst,
   output logic        pix_en,
   output logic [9:0]  hCount,
   output logic [9:0]  vCount,
   output logic        bright,
   input  logic [11:0] rgb_in,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        hsync,
   output logic        vsync,
   output logic        line_tick,
   output logic        vblank_tick,
   output logic        frame_tick
);

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [10:0] HS_END = 11'(H_SYNC);
   localparam logic [10:0] VS_END = 11'(V_SYNC);
   localparam logic [10:0] V_BLANK_LINE = 11'(V_DISP_END);

   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   rgb_t       rgb_q, rgb_d;
   logic       line_q, line_d;
   logic       vblank_q, vblank_d;
   logic       frame_q, frame_d;

   clk_en_div #(.DIV(CLK_DIV)) u_pix_div (
      .clk (clk),
      .rst (rst),
      .en  (pix_en)
   );

   // Counter advance, decode and next values of every registered output.
   always_comb begin
      h_d      = h_q;
      v_d      = v_q;
      hsync_d  = hsync_q;
      vsync_d  = vsync_q;
      rgb_d    = rgb_q;
      line_d   = 1'b0;
      vblank_d = 1'b0;
      frame_d  = 1'b0;
      bright   = in_window({1'b0, h_q}, 11'(H_DISP_START), 11'(H_DISP_END)) &&
                 in_window({1'b0, v_q}, 11'(V_DISP_START), 11'(V_DISP_END));
      if (pix_en) begin
         if (h_q == H_LAST) begin
            h_d = 10'd0;
            if (v_q == V_LAST) begin
               v_d = 10'd0;
            end else begin
               v_d = v_q + 10'd1;
            end
         end else begin
            h_d = h_q + 10'd1;
         end
         // Pins show the pixel the counters held before this edge.
         hsync_d  = ~({1'b0, h_q} < HS_END);
         vsync_d  = ~({1'b0, v_q} < VS_END);
         rgb_d    = bright ? rgb_t'(rgb_in) : rgb_t'(12'h000);
         line_d   = (h_d == 10'd0);
         vblank_d = (h_d == 10'd0) && ({1'b0, v_d} == V_BLANK_LINE);
         frame_d  = (h_d == 10'd0) && (v_d == 10'd0);
      end else begin
         line_d   = 1'b0;
      end
   end

   // All timing state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q      <= 10'd0;
         v_q      <= 10'd0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         rgb_q    <= rgb_t'(12'h000);
         line_q   <= 1'b0;
         vblank_q <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         h_q      <= h_d;
         v_q      <= v_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         rgb_q    <= rgb_d;
         line_q   <= line_d;
         vblank_q <= vblank_d;
         frame_q  <= frame_d;
      end
   end

   assign hCount      = h_q;
   assign vCount      = v_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign vga_r       = rgb_q.r;
   assign vga_g       = rgb_q.g;
   assign vga_b       = rgb_q.b;
   assign line_tick   = line_q;
   assign vblank_tick = vblank_q;
   assign frame_tick  = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing plus two shrunken geometries
// (CLK_DIV=3 and CLK_DIV=1), checked every cycle against a time-based model.
module tb_vga_timing_gen;

   typedef struct packed {
      int d; int h; int hs; int hds; int hde; int v; int vs; int vds; int vde;
   } geo_t;

   localparam geo_t GA = '{d:4, h:800, hs:96, hds:144, hde:784, v:525, vs:2, vds:35, vde:515};
   localparam geo_t GB = '{d:3, h:20, hs:3, hds:5, hde:17, v:12, vs:2, vds:3, vde:10};
   localparam geo_t GC = '{d:1, h:20, hs:3, hds:5, hde:17, v:12, vs:2, vds:3, vde:10};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   t = 0;
   int   tests = 0;
   int   fails = 0;

   logic [11:0] rgb_a = 12'hF0F, rgb_b = 12'h000, rgb_c = 12'h000;
   logic       pe_a, br_a, hs_a, vs_a, lt_a, vb_a, ft_a;
   logic       pe_b, br_b, hs_b, vs_b, lt_b, vb_b, ft_b;
   logic       pe_c, br_c, hs_c, vs_c, lt_c, vb_c, ft_c;
   logic [9:0] hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
   logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

   always #5 clk = ~clk;

   vga_timing_gen u_a (
      .clk(clk), .rst(rst), .pix_en(pe_a), .hCount(hc_a), .vCount(vc_a), .bright(br_a),
      .rgb_in(rgb_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .hsync(hs_a), .vsync(vs_a),
      .line_tick(lt_a), .vblank_tick(vb_a), .frame_tick(ft_a));

   vga_timing_gen #(.CLK_DIV(3), .H_TOTAL(20), .H_SYNC(3), .H_DISP_START(5), .H_DISP_END(17),
                    .V_TOTAL(12), .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(10)) u_b (
      .clk(clk), .rst(rst), .pix_en(pe_b), .hCount(hc_b), .vCount(vc_b), .bright(br_b),
      .rgb_in(rgb_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .hsync(hs_b), .vsync(vs_b),
      .line_tick(lt_b), .vblank_tick(vb_b), .frame_tick(ft_b));

   vga_timing_gen #(.CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_DISP_START(5), .H_DISP_END(17),
                    .V_TOTAL(12), .V_SYNC(2), .V_DISP_START(3), .V_DISP_END(10)) u_c (
      .clk(clk), .rst(rst), .pix_en(pe_c), .hCount(hc_c), .vCount(vc_c), .bright(br_c),
      .rgb_in(rgb_c), .vga_r(r_c), .vga_g(g_c), .vga_b(b_c), .hsync(hs_c), .vsync(vs_c),
      .line_tick(lt_c), .vblank_tick(vb_c), .frame_tick(ft_c));

   function automatic logic [11:0] colour(int h, int v, bit pat);
      if (pat) return 12'((h * 37 + v * 101) % 4096);
      return 12'hF0F;
   endfunction

   function automatic bit visible(geo_t g, int h, int v);
      return (h >= g.hds) && (h < g.hde) && (v >= g.vds) && (v < g.vde);
   endfunction

   // Everything follows from the number of clock edges t since reset release.
   function automatic logic [38:0] model(geo_t g, int tt, bit pat);
      int p, pos, h, v, pp, ph, pv;
      bit pe, br, hs, vs, tk, lt, vt, ft;
      logic [11:0] c;
      p   = tt / g.d;
      pos = p % (g.h * g.v);
      h   = pos % g.h;
      v   = pos / g.h;
      pe  = (tt % g.d) == (g.d - 1);
      br  = visible(g, h, v);
      hs  = 1'b1; vs = 1'b1; c = 12'h000;
      if (p > 0) begin
         pp = (p - 1) % (g.h * g.v);
         ph = pp % g.h;
         pv = pp / g.h;
         hs = !(ph < g.hs);
         vs = !(pv < g.vs);
         if (visible(g, ph, pv)) c = colour(ph, pv, pat);
      end
      tk = (p > 0) && ((tt % g.d) == 0);
      lt = tk && (h == 0);
      vt = lt && (v == g.vde);
      ft = lt && (v == 0);
      return {pe, 10'(h), 10'(v), br, hs, vs, c, lt, vt, ft};
   endfunction

   function automatic logic [11:0] cur_colour(geo_t g, int tt);
      int pos;
      pos = (tt / g.d) % (g.h * g.v);
      return colour(pos % g.h, pos / g.h, 1'b1);
   endfunction

   task automatic cmp_cycle(string nm, logic [38:0] got, logic [38:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL cyc_%s t=%0d got=%h exp=%h", nm, t, got, exp);
      end
   endtask

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) t <= 0;
      else     t <= t + 1;
   end

   // Per-cycle comparison against the model, then next renderer colour.
   always @(negedge clk) begin
      cmp_cycle("A", {pe_a, hc_a, vc_a, br_a, hs_a, vs_a, r_a, g_a, b_a, lt_a, vb_a, ft_a}, model(GA, t, 1'b0));
      cmp_cycle("B", {pe_b, hc_b, vc_b, br_b, hs_b, vs_b, r_b, g_b, b_b, lt_b, vb_b, ft_b}, model(GB, t, 1'b1));
      cmp_cycle("C", {pe_c, hc_c, vc_c, br_c, hs_c, vs_c, r_c, g_c, b_c, lt_c, vb_c, ft_c}, model(GC, t, 1'b1));
      rgb_b = cur_colour(GB, t);
      rgb_c = cur_colour(GC, t);
   end

   int cyc = 0;
   int a_lt_last = -1, b_ft_last = -1, c_ft_last = -1;
   int a_lt_iv = 0, b_ft_iv = 0, c_ft_iv = 0;
   int a_hs_cnt = 0, a_hs_run = 0, b_vs_cnt = 0, b_vs_run = 0, c_vs_cnt = 0, c_vs_run = 0;
   int a_lines = 0, a_ft_cnt = 0, a_vb_cnt = 0, max_h_a = 0, max_h_b = 0, max_v_b = 0;

   // Interval and run-length measurements straight from the pins.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         a_lt_last = -1; b_ft_last = -1; c_ft_last = -1;
         a_hs_cnt = 0; b_vs_cnt = 0; c_vs_cnt = 0;
      end else begin
         if (lt_a) begin
            a_lines++;
            if (a_lt_last >= 0) a_lt_iv = cyc - a_lt_last;
            a_lt_last = cyc;
         end
         if (ft_a) a_ft_cnt++;
         if (vb_a) a_vb_cnt++;
         if (ft_b) begin
            if (b_ft_last >= 0) b_ft_iv = cyc - b_ft_last;
            b_ft_last = cyc;
         end
         if (ft_c) begin
            if (c_ft_last >= 0) c_ft_iv = cyc - c_ft_last;
            c_ft_last = cyc;
         end
         if (!hs_a) a_hs_cnt++;
         else if (a_hs_cnt != 0) begin a_hs_run = a_hs_cnt; a_hs_cnt = 0; end
         if (!vs_b) b_vs_cnt++;
         else if (b_vs_cnt != 0) begin b_vs_run = b_vs_cnt; b_vs_cnt = 0; end
         if (!vs_c) c_vs_cnt++;
         else if (c_vs_cnt != 0) begin c_vs_run = c_vs_cnt; c_vs_cnt = 0; end
         if (int'(hc_a) > max_h_a) max_h_a = int'(hc_a);
         if (int'(hc_b) > max_h_b) max_h_b = int'(hc_b);
         if (int'(vc_b) > max_v_b) max_v_b = int'(vc_b);
      end
   end

   // Called right after release: pix_en pattern over the first four clocks
   // (high only in the fourth), then hCount=1 after the first pixel edge.
   task automatic post_release(string nm);
      logic [3:0] seen;
      seen = 4'b0000;
      #1 seen[0] = pe_a;
      for (int i = 1; i < 4; i++) begin
         @(posedge clk); @(negedge clk); #1;
         seen[i] = pe_a;
      end
      chk({nm, "_pix_en_first"}, 64'(seen), 64'(4'b1000));
      @(posedge clk); @(negedge clk); #1;
      chk({nm, "_hcount_first"}, 64'({hc_a, vc_a, pe_a}), 64'({10'd1, 10'd0, 1'b0}));
   endtask

   initial begin
      rst = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      post_release("rel1");
      // t=35240 -> pixel 8810 = line 11, column 10.
      repeat (35236) @(posedge clk);
      @(negedge clk); #1;
      chk("a_position",     64'({hc_a, vc_a}), 64'({10'd10, 10'd11}));
      chk("a_line_count",   64'(a_lines), 64'd11);
      chk("a_no_frame_vbl", 64'({a_ft_cnt, a_vb_cnt}), 64'd0);
      chk("a_line_period",  64'(a_lt_iv), 64'd3200);
      chk("a_hsync_low",    64'(a_hs_run), 64'd384);
      chk("a_max_h",        64'(max_h_a), 64'd799);
      chk("b_frame_period", 64'(b_ft_iv), 64'd720);
      chk("b_vsync_low",    64'(b_vs_run), 64'd120);
      chk("b_max_hv",       64'({max_h_b, max_v_b}), {32'd19, 32'd11});
      chk("c_frame_period", 64'(c_ft_iv), 64'd240);
      chk("c_vsync_low",    64'(c_vs_run), 64'd40);

      // Asynchronous reset between clock edges must clear outputs at once.
      @(posedge clk); #2 rst = 1'b1; #1;
      chk("a_async_rst", 64'({hc_a, vc_a, hs_a, vs_a, r_a, g_a, b_a, lt_a}),
          64'({10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0}));
      chk("c_async_rst", 64'({hc_c, vc_c, hs_c, vs_c, r_c, g_c, b_c, lt_c, ft_c}),
          64'({10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0}));
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      post_release("rel2");
      // t=7004 -> pixel 1751 = line 2, column 151.
      repeat (7000) @(posedge clk);
      @(negedge clk); #1;
      chk("a_position2",   64'({hc_a, vc_a}), 64'({10'd151, 10'd2}));
      chk("a_line_period2", 64'(a_lt_iv), 64'd3200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing master for the 640x480@60 Hz VGA path; the producing end of the hCount/vCount/bright interface that the game drawing logic (block/paddle/ball renderer) consumes.
- Divides the 100 MHz board clock to a 25 MHz pixel enable and runs the horizontal/vertical counters.
- Decodes bright, hsync and vsync, and registers the renderer's combinational rgb into the pin outputs with sync aligned to it.
- Emits per-line, vertical-blank and per-frame strobes so game-state updates can run once per frame instead of on a separately divided slow clock.

Parameters:
CLK_DIV, 4, clk cycles per pixel (>=1; 1 means pix_en is constantly high)
H_TOTAL, 800, clocks per line
H_SYNC, 96, hsync low for hCount 0..H_SYNC-1
H_DISP_START, 144, first visible column
H_DISP_END, 784, first column after the visible area
V_TOTAL, 525, lines per frame
V_SYNC, 2, vsync low for vCount 0..V_SYNC-1
V_DISP_START, 35, first visible line
V_DISP_END, 515, first line after the visible area

Ports:
clk  in  1  100 MHz system clock
rst  in  1  reset, asynchronous, active-high
pix_en  out  1  one-clk pixel strobe, every CLK_DIV clocks
hCount  out  10  current column, 0..H_TOTAL-1
vCount  out  10  current line, 0..V_TOTAL-1
bright  out  1  combinational: counters are inside the visible window
rgb_in  in  12  renderer colour for the current (hCount,vCount), {R,G,B} 4 bits each
vga_r  out  4  registered red
vga_g  out  4  registered green
vga_b  out  4  registered blue
hsync  out  1  registered, active-low
vsync  out  1  registered, active-low
line_tick  out  1  one-clk pulse at the start of each line
vblank_tick  out  1  one-clk pulse when vertical blanking begins
frame_tick  out  1  one-clk pulse at the start of each frame

Behaviour:
- Reset (async, clk domain): divider=0, hCount=0, vCount=0, vga_r/g/b=0, hsync=1, vsync=1, all ticks=0.
- Reset mid-line or mid-frame takes effect immediately with no partial-line recovery; counting restarts at (0,0) on release.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 combinationally when div==CLK_DIV-1.
  - After reset release, the first pix_en occurs in the CLK_DIV-th clk.
- Counters advance only on clk edges where pix_en=1:
  - hCount==H_TOTAL-1: hCount->0; vCount->vCount+1, or 0 if vCount==V_TOTAL-1.
  - Otherwise hCount->hCount+1.
  - No other state changes counters; no count values outside their ranges are ever produced.
- bright = (H_DISP_START<=hCount<H_DISP_END) && (V_DISP_START<=vCount<V_DISP_END). Combinational from the counter registers so the renderer sees it in the same pixel.
- Output stage, registered on pix_en:
  - hsync <= ~(hCount<H_SYNC); vsync <= ~(vCount<V_SYNC).
  - {vga_r,vga_g,vga_b} <= bright ? rgb_in : 0.
  - Latency is one pixel (CLK_DIV clks) from counter value to pins. Sync and colour share the same delay and therefore stay aligned.
  - Blanking is forced here regardless of rgb_in.
- Ticks (registered, high for exactly one clk, on the clk after the pix_en edge that produced the new position):
  - line_tick: new hCount==0.
  - vblank_tick: new (hCount,vCount)==(0,V_DISP_END).
  - frame_tick: new (0,0).
  - frame_tick and line_tick assert together at frame wrap.
  - No tick is produced on the reset release itself.
- Widths and arithmetic:
  - All counters are 10 bits unsigned; parameters must be <=1024.
  - Divider width is $clog2(CLK_DIV), minimum 1.
  - Comparisons are unsigned with no wrap arithmetic.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clk at the defaults.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants listed above.
  - Colour localparams: RED, WHITE, PINK, BLUE, BRIGHT_GREEN, BLACK, PURPLE.
  - Screen-edge constants used by the renderer.
- Sub-module clk_en_div (parameter DIV; ports clk, rst, en) generates pix_en and is reused for other slow strobes.
- Counters, decode and output stage stay in vga_timing_gen.

Test Plan:
1. Reset held 10 clk, released -> pix_en first at clk 4 after release; hCount 0->1 on that edge; hsync=vsync=1 and rgb=0 throughout reset.
2. Run to hCount=799, vCount=10 -> next pix_en gives hCount=0, vCount=11; line_tick=1 for exactly one clk; vblank_tick and frame_tick stay 0.
3. hsync timing on one line -> hsync low for 96 consecutive pixel periods (384 clk), first low pixel is one pixel after hCount=0; high for the remaining 704 pixels.
4. rgb_in=12'hF0F constant, vCount=100 -> vga out 0/0/0 while registered hCount<=143; F/0/F for columns 144..783; 0 from 784. At vCount=515, rgb is always 0 and vblank_tick pulses once at (0,515).
5. Free-run two frames -> frame_tick pulses exactly 1,680,000 clk apart; vsync low exactly 2 lines (6400 clk) per frame; no counter value exceeds 799/524.
6. Async rst asserted mid-clock at hCount=300, vCount=200 -> hCount=vCount=0, hsync=vsync=1, rgb=0 before the next clk edge; after release, test 1 timing repeats exactly.
